debug_step_console: RTL and testbench

Parametrised board-level debug console that generalises the board test harness: it turns DE2 push-buttons and a mode switch into a debounced single-step or free-running clock enable for the CPU. It counts executed steps and multiplexes one of N_CH probed CPU channels onto hex-digit nibbles for the seven-segment decoders. It sits in the top-level test module between the board I/O and the CPU/decoder instances.

---
 rtl/debug_step_console.sv | 150 +++++++++++++++
 tb/tb_debug_step_console.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/debug_step_console.sv
`default_nettype none
// ============================================================================
// debug_step_console : debounced single-step / free-run CPU clock enable,
//                      step counter and held channel probe for hex displays
// Revision 1.0
// ============================================================================
module debug_step_console #(
  parameter int DATA_W       = 8,
  parameter int N_CH         = 4,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int AUTO_DIV     = 25000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_step_n,
  input  logic                    key_page_n,
  input  logic                    mode_run,
  input  logic [N_CH*DATA_W-1:0]  ch_data,
  output logic                    cpu_en,
  output logic [15:0]             step_count,
  output logic [$clog2(N_CH)-1:0] ch_sel,
  output logic [31:0]             hex_nib,
  output logic                    heartbeat
);

  localparam int c_SEL_W = $clog2(N_CH);
  localparam int c_DB_W  = $clog2(DEBOUNCE_CYC);
  localparam int c_DIV_W = $clog2(AUTO_DIV);
  localparam logic [c_DB_W-1:0]  c_DB_LAST  = c_DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(AUTO_DIV - 1);
  localparam logic [c_SEL_W-1:0] c_SEL_LAST = c_SEL_W'(N_CH - 1);

  logic [1:0]         w_key_raw;
  logic [1:0]         r_key_s1;
  logic [1:0]         r_key_s2;
  logic [1:0]         w_key_evt;
  logic               r_mode_s1;
  logic               r_mode_s2;
  logic               w_mode_chg;
  logic               w_step_evt;
  logic               w_page_evt;
  logic               w_run_tick;
  logic [c_DIV_W-1:0] r_div;
  logic [15:0]        r_step_count;
  logic               r_heartbeat;
  logic [c_SEL_W-1:0] r_ch_sel;
  logic [c_SEL_W-1:0] w_ch_sel_nxt;
  logic [DATA_W-1:0]  r_hold;
  logic [DATA_W-1:0]  w_ch_word;

  assign w_key_raw = {key_page_n, key_step_n};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_s1  <= 2'b11;
      r_key_s2  <= 2'b11;
      r_mode_s1 <= 1'b0;
      r_mode_s2 <= 1'b0;
    end else begin
      r_key_s1  <= w_key_raw;
      r_key_s2  <= r_key_s1;
      r_mode_s1 <= mode_run;
      r_mode_s2 <= r_mode_s1;
    end
  end

  // Index 0 = step key, index 1 = page key; only a falling accepted level is an event.
  for (genvar gi = 0; gi < 2; gi++) begin : g_key
    logic [c_DB_W-1:0] r_cnt;
    logic              r_lvl;
    logic              r_lvl_d;
    logic              r_evt;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt   <= '0;
        r_lvl   <= 1'b1;
        r_lvl_d <= 1'b1;
        r_evt   <= 1'b0;
      end else begin
        if (r_key_s2[gi] == r_lvl) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DB_LAST) begin
          r_lvl <= r_key_s2[gi];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_DB_W'(1);
        end
        r_lvl_d <= r_lvl;
        r_evt   <= r_lvl_d & ~r_lvl;
      end
    end

    assign w_key_evt[gi] = r_evt;
  end

  assign w_step_evt = w_key_evt[0];
  assign w_page_evt = w_key_evt[1];

  // A mode flip is caught one stage early so the divider restarts as the new level lands.
  assign w_mode_chg = r_mode_s1 ^ r_mode_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
    end else if (w_mode_chg || !r_mode_s2 || (r_div == c_DIV_LAST)) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + c_DIV_W'(1);
    end
  end

  assign w_run_tick = (r_div == c_DIV_LAST);
  assign cpu_en     = !rst && (r_mode_s2 ? w_run_tick : w_step_evt);

  assign w_ch_sel_nxt = !w_page_evt ? r_ch_sel :
                        (r_ch_sel == c_SEL_LAST) ? '0 : r_ch_sel + c_SEL_W'(1);
  assign w_ch_word    = ch_data[int'(w_ch_sel_nxt) * DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step_count <= '0;
      r_heartbeat  <= 1'b0;
      r_ch_sel     <= '0;
      r_hold       <= '0;
    end else begin
      if (cpu_en) begin
        r_step_count <= r_step_count + 16'd1;
        r_heartbeat  <= ~r_heartbeat;
      end
      r_ch_sel <= w_ch_sel_nxt;
      if (cpu_en || w_page_evt) begin
        r_hold <= w_ch_word;
      end
    end
  end

  assign step_count     = r_step_count;
  assign heartbeat      = r_heartbeat;
  assign ch_sel         = r_ch_sel;
  assign hex_nib[31:16] = r_step_count;

  if (DATA_W < 16) begin : g_pad
    assign hex_nib[15:0] = {{(16 - DATA_W){1'b0}}, r_hold};
  end else begin : g_full
    assign hex_nib[15:0] = r_hold;
  end

endmodule
`default_nettype wire

// File: tb/tb_debug_step_console.sv
`default_nettype none
// tb_debug_step_console : scoreboard bench for the step/run console
// Revision 1.0
module tb_debug_step_console;

  localparam int DATA_W = 8;
  localparam int N_CH   = 4;
  localparam int DBC    = 4;
  localparam int DIV    = 10;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   key_step_n;
  logic                   key_page_n;
  logic                   mode_run;
  logic [N_CH*DATA_W-1:0] ch_data;
  logic                   cpu_en;
  logic [15:0]            step_count;
  logic [1:0]             ch_sel;
  logic [31:0]            hex_nib;
  logic                   heartbeat;

  debug_step_console #(
    .DATA_W(DATA_W), .N_CH(N_CH), .DEBOUNCE_CYC(DBC), .AUTO_DIV(DIV)
  ) dut (
    .clk(clk), .rst(rst), .key_step_n(key_step_n), .key_page_n(key_page_n),
    .mode_run(mode_run), .ch_data(ch_data), .cpu_en(cpu_en),
    .step_count(step_count), .ch_sel(ch_sel), .hex_nib(hex_nib),
    .heartbeat(heartbeat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [15:0] cnt; logic hb; } en_t;
  typedef struct { int cyc; logic [1:0] sel; logic [15:0] nib; } disp_t;

  en_t         en_q[$];
  disp_t       disp_q[$];
  logic [7:0]  ch_val [4];
  logic [15:0] m_cnt;
  logic        m_hb;
  logic [1:0]  m_sel;
  int          nxt;
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          mon_on  = 1'b0;
  bit          pend    = 1'b0;
  en_t         pend_e;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard: pulses and display values are matched against queued expectations.
  always @(negedge clk) begin : mon
    en_t   e;
    disp_t d;
    if (mon_on) begin
      if (pend) begin
        check("step_count", step_count, pend_e.cnt);
        check("hex_hi", hex_nib[31:16], pend_e.cnt);
        check("heartbeat", heartbeat, pend_e.hb);
        pend <= 1'b0;
      end
      if (cpu_en) begin
        if (en_q.size() == 0) begin
          check("en_unexpected", cpu_en, 1'b0);
        end else begin
          e = en_q.pop_front();
          check("en_cycle", cyc, e.cyc);
          pend_e <= e;
          pend   <= 1'b1;
        end
      end else if (en_q.size() > 0 && en_q[0].cyc < cyc) begin
        e = en_q.pop_front();
        check("en_missing_at", cyc, e.cyc);
      end
      if (disp_q.size() > 0 && disp_q[0].cyc <= cyc) begin
        d = disp_q.pop_front();
        check("ch_sel", ch_sel, d.sel);
        check("hex_lo", hex_nib[15:0], d.nib);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_pulse(input int c);
    en_t e;
    m_cnt = m_cnt + 16'd1;
    m_hb  = ~m_hb;
    e.cyc = c;
    e.cnt = m_cnt;
    e.hb  = m_hb;
    en_q.push_back(e);
  endtask

  task automatic push_run(input int upto);
    while (nxt <= upto) begin
      push_pulse(nxt);
      nxt += DIV;
    end
  endtask

  // A press driven just after edge d gives its event DBC+3 edges later.
  task automatic press(input bit page, input int hold, input bit expect_en);
    int    d;
    disp_t q;
    d = cyc;
    if (page) key_page_n = 1'b0;
    else      key_step_n = 1'b0;
    if (page) begin
      m_sel = (m_sel == 2'(N_CH - 1)) ? 2'd0 : m_sel + 2'd1;
    end else if (expect_en) begin
      push_pulse(d + DBC + 3);
    end
    if (page || expect_en) begin
      q.cyc = d + DBC + 4;
      q.sel = m_sel;
      q.nib = {8'h00, ch_val[m_sel]};
      disp_q.push_back(q);
    end
    tick(hold);
    key_step_n = 1'b1;
    key_page_n = 1'b1;
    tick(DBC + 6);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : main
    int d0;
    int r;
    ch_val[0] = 8'h11; ch_val[1] = 8'h22; ch_val[2] = 8'h33; ch_val[3] = 8'h44;
    ch_data    = {ch_val[3], ch_val[2], ch_val[1], ch_val[0]};
    rst        = 1'b1;
    key_step_n = 1'b1;
    key_page_n = 1'b1;
    mode_run   = 1'b0;
    m_cnt      = '0;
    m_hb       = 1'b0;
    m_sel      = '0;
    nxt        = 0;
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cpu_en", cpu_en, 1'b0);
    check("rst_step_count", step_count, 16'h0);
    check("rst_ch_sel", ch_sel, 2'd0);
    check("rst_hex_nib", hex_nib, 32'h0);
    check("rst_heartbeat", heartbeat, 1'b0);
    mon_on = 1'b1;
    tick(1);

    // Step mode: long hold gives one pulse, short glitch gives none.
    press(1'b0, 20, 1'b1);
    press(1'b0, 3, 1'b0);
    @(negedge clk);
    check("glitch_count", step_count, m_cnt);
    tick(1);

    // Page through every channel and wrap back to 0.
    for (int i = 0; i < N_CH; i++) press(1'b1, 8, 1'b0);

    // Run mode: pulses every DIV cycles, step presses ignored.
    mode_run = 1'b1;
    d0  = cyc;
    nxt = d0 + DIV + 1;
    push_run(d0 + 80);
    tick(2);
    press(1'b0, 8, 1'b0);
    press(1'b0, 8, 1'b0);
    wait_until(d0 + 74);

    // Counter wrap from 0xFFFF to 0x0000.
    dut.r_step_count = 16'hFFFE;
    m_cnt = 16'hFFFE;
    push_run(d0 + 95);
    wait_until(d0 + 98);

    // Reset two cycles before the next run pulse.
    wait_until(nxt - 2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    r   = cyc;
    @(negedge clk);
    check("mid_rst_cpu_en", cpu_en, 1'b0);
    check("mid_rst_step_count", step_count, 16'h0);
    check("mid_rst_ch_sel", ch_sel, 2'd0);
    check("mid_rst_hex_nib", hex_nib, 32'h0);
    check("mid_rst_heartbeat", heartbeat, 1'b0);
    m_cnt = '0;
    m_hb  = 1'b0;
    m_sel = '0;
    nxt   = r + DIV + 1;
    push_run(r + DIV + 1);
    tick(1);
    @(negedge clk);
    check("post_rst_cpu_en", cpu_en, 1'b0);
    tick(1);
    wait_until(r + DIV + 5);

    check("en_q_left", en_q.size(), 0);
    check("disp_q_left", disp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
